hazard_stall_unit: RTL and testbench

//  Pipeline stall/bubble controller; companion to the forwarding unit. Forwarding resolves RAW

---
 rtl/hazard_stall_unit.sv | 145 ++++++++++++++
 tb/tb_hazard_stall_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: pipeline stall/bubble controller sitting beside the forwarding unit.
// It covers the hazards that forwarding cannot: load-use, D-mem wait, the second access of
// LDI/STI, and I-mem wait. It also keeps saturating stall performance counters.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   id_sr1_id/id_sr2_id, id_uses_*   ID-stage source registers and whether each is really read
//   ex_dest, ex_load_regfile, ex_is_load   EX-stage destination and load info
//   mem_valid, mem_dmem_req, mem_indirect, dmem_resp   MEM-stage D-mem handshake
//   if_imem_req, imem_resp           IF-stage I-mem handshake
//   perf_clear                       synchronous clear of all counters
//   stall_*, *_bubble                combinational stage-hold and NOP-insert controls
//   mem_ind_phase                    second indirect D-mem access in progress
//   lu_count/dstall_count/istall_count   saturating event counters
module hazard_stall_unit #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2:0]           id_sr1_id,
    input  logic [2:0]           id_sr2_id,
    input  logic                 id_uses_sr1,
    input  logic                 id_uses_sr2,
    input  logic [2:0]           ex_dest,
    input  logic                 ex_load_regfile,
    input  logic                 ex_is_load,
    input  logic                 mem_valid,
    input  logic                 mem_dmem_req,
    input  logic                 mem_indirect,
    input  logic                 dmem_resp,
    input  logic                 if_imem_req,
    input  logic                 imem_resp,
    input  logic                 perf_clear,
    output logic                 stall_if,
    output logic                 stall_id,
    output logic                 stall_ex,
    output logic                 stall_mem,
    output logic                 id_bubble,
    output logic                 ex_bubble,
    output logic                 wb_bubble,
    output logic                 mem_ind_phase,
    output logic [CNT_WIDTH-1:0] lu_count,
    output logic [CNT_WIDTH-1:0] dstall_count,
    output logic [CNT_WIDTH-1:0] istall_count
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_IND2 = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    state_t state;
    state_t state_nxt;

    logic mem_stall;
    logic load_use;
    logic imem_wait;

    // Hazard detection; the first access of an indirect op keeps MEM held even on response
    always_comb begin
        mem_stall = mem_valid & mem_dmem_req &
                    (~dmem_resp | ((state == ST_RUN) & mem_indirect));
        load_use  = ex_is_load & ex_load_regfile &
                    ((id_uses_sr1 & (ex_dest == id_sr1_id)) |
                     (id_uses_sr2 & (ex_dest == id_sr2_id)));
        imem_wait = if_imem_req & ~imem_resp;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and prioritised stall/bubble controls
    always_comb begin
        state_nxt     = state;
        stall_if      = 1'b0;
        stall_id      = 1'b0;
        stall_ex      = 1'b0;
        stall_mem     = 1'b0;
        id_bubble     = 1'b0;
        ex_bubble     = 1'b0;
        wb_bubble     = 1'b0;
        mem_ind_phase = (state == ST_IND2);

        case (state)
            ST_RUN: begin
                if (mem_valid & mem_indirect & mem_dmem_req & dmem_resp) begin
                    state_nxt = ST_IND2;
                end
            end
            ST_IND2: begin
                if (dmem_resp) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_RUN;
        endcase

        if (mem_stall) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
            wb_bubble = 1'b1;
        end else if (load_use) begin
            // One bubble; the load then sits in MEM and forwarding covers it from WB
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            ex_bubble = 1'b1;
        end else if (imem_wait) begin
            stall_if  = 1'b1;
            id_bubble = 1'b1;
        end
    end

    // Saturating performance counters; clear wins over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_count     <= '0;
            dstall_count <= '0;
            istall_count <= '0;
        end else if (perf_clear) begin
            lu_count     <= '0;
            dstall_count <= '0;
            istall_count <= '0;
        end else begin
            if (ex_bubble && (lu_count != CNT_MAX)) begin
                lu_count <= lu_count + CNT_WIDTH'(1);
            end
            if (stall_mem && (dstall_count != CNT_MAX)) begin
                dstall_count <= dstall_count + CNT_WIDTH'(1);
            end
            if (id_bubble && (istall_count != CNT_MAX)) begin
                istall_count <= istall_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: directed scenarios plus randomized traffic,
// all compared against a behavioural model of the stall rules and counters.
module tb_hazard_stall_unit;

    localparam int unsigned CNT_WIDTH = 16;
    localparam int CMAX = 65535;

    logic clk = 1'b0;
    logic rst_n;
    logic [2:0] id_sr1_id, id_sr2_id, ex_dest;
    logic id_uses_sr1, id_uses_sr2, ex_load_regfile, ex_is_load;
    logic mem_valid, mem_dmem_req, mem_indirect, dmem_resp;
    logic if_imem_req, imem_resp, perf_clear;
    logic stall_if, stall_id, stall_ex, stall_mem;
    logic id_bubble, ex_bubble, wb_bubble, mem_ind_phase;
    logic [CNT_WIDTH-1:0] lu_count, dstall_count, istall_count;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: whether the second indirect access is pending, and counter values
    bit m_phase;
    int m_lu, m_ds, m_is;

    always #5 clk = ~clk;

    hazard_stall_unit #(.CNT_WIDTH(CNT_WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_sr1_id(id_sr1_id), .id_sr2_id(id_sr2_id),
        .id_uses_sr1(id_uses_sr1), .id_uses_sr2(id_uses_sr2),
        .ex_dest(ex_dest), .ex_load_regfile(ex_load_regfile), .ex_is_load(ex_is_load),
        .mem_valid(mem_valid), .mem_dmem_req(mem_dmem_req), .mem_indirect(mem_indirect),
        .dmem_resp(dmem_resp), .if_imem_req(if_imem_req), .imem_resp(imem_resp),
        .perf_clear(perf_clear),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
        .id_bubble(id_bubble), .ex_bubble(ex_bubble), .wb_bubble(wb_bubble),
        .mem_ind_phase(mem_ind_phase),
        .lu_count(lu_count), .dstall_count(dstall_count), .istall_count(istall_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected {stall_if,stall_id,stall_ex,stall_mem,id_bubble,ex_bubble,wb_bubble,ind_phase}
    function automatic logic [7:0] model_ctrl();
        bit ms, lu, iw;
        ms = mem_valid && mem_dmem_req && (!dmem_resp || (!m_phase && mem_indirect));
        lu = ex_is_load && ex_load_regfile &&
             ((id_uses_sr1 && (ex_dest == id_sr1_id)) || (id_uses_sr2 && (ex_dest == id_sr2_id)));
        iw = if_imem_req && !imem_resp;
        if (ms)      return {7'b1111_001, m_phase};
        else if (lu) return {7'b1100_010, m_phase};
        else if (iw) return {7'b1000_100, m_phase};
        else         return {7'b0000_000, m_phase};
    endfunction

    function automatic logic [7:0] dut_ctrl();
        return {stall_if, stall_id, stall_ex, stall_mem, id_bubble, ex_bubble, wb_bubble,
                mem_ind_phase};
    endfunction

    task automatic model_reset();
        m_phase = 1'b0;
        m_lu = 0; m_ds = 0; m_is = 0;
    endtask

    task automatic idle_inputs();
        id_sr1_id = 3'd0; id_sr2_id = 3'd0; ex_dest = 3'd0;
        id_uses_sr1 = 1'b0; id_uses_sr2 = 1'b0; ex_load_regfile = 1'b0; ex_is_load = 1'b0;
        mem_valid = 1'b0; mem_dmem_req = 1'b0; mem_indirect = 1'b0; dmem_resp = 1'b0;
        if_imem_req = 1'b0; imem_resp = 1'b0; perf_clear = 1'b0;
    endtask

    // Called at posedge+1 with inputs set; checks mid-cycle, then advances the model on the edge
    task automatic cycle(input bit chk, input string tag);
        logic [7:0] exp;
        #3;
        exp = model_ctrl();
        if (chk) begin
            check({tag, ".ctrl"}, 32'(dut_ctrl()), 32'(exp));
            check({tag, ".lu"}, 32'(lu_count), 32'(m_lu));
            check({tag, ".ds"}, 32'(dstall_count), 32'(m_ds));
            check({tag, ".is"}, 32'(istall_count), 32'(m_is));
        end
        @(posedge clk);
        if (perf_clear) begin
            m_lu = 0; m_ds = 0; m_is = 0;
        end else begin
            if (exp[2] && m_lu < CMAX) m_lu++;
            if (exp[4] && m_ds < CMAX) m_ds++;
            if (exp[3] && m_is < CMAX) m_is++;
        end
        if (!m_phase) m_phase = mem_valid && mem_indirect && mem_dmem_req && dmem_resp;
        else if (dmem_resp) m_phase = 1'b0;
        #1;
    endtask

    initial begin
        int ds_start;
        logic [3:0] ind_resp;
        idle_inputs();
        model_reset();
        rst_n = 1'b0;
        #12;
        check("reset.ctrl", 32'(dut_ctrl()), 32'(8'h00));
        check("reset.cnt", 32'({lu_count, dstall_count, istall_count} == '0), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Load-use: LDR R1 in EX, ADD in ID reads R1 via SR2
        ex_dest = 3'd1; ex_is_load = 1'b1; ex_load_regfile = 1'b1;
        id_sr1_id = 3'd2; id_uses_sr1 = 1'b1; id_sr2_id = 3'd1; id_uses_sr2 = 1'b1;
        mem_valid = 1'b1; mem_dmem_req = 1'b1; dmem_resp = 1'b1;
        cycle(1, "hazard");
        ex_is_load = 1'b0; ex_load_regfile = 1'b0;
        cycle(1, "hazard_after");
        check("hazard.lu_count", 32'(lu_count), 32'd1);

        // No hazard: matching register but unused source, or non-load in EX
        idle_inputs();
        ex_dest = 3'd1; ex_is_load = 1'b1; ex_load_regfile = 1'b1;
        id_sr1_id = 3'd1; id_uses_sr1 = 1'b0;
        cycle(1, "nohaz_unused");
        ex_is_load = 1'b0; id_uses_sr1 = 1'b1;
        cycle(1, "nohaz_notload");

        // LDI with three wait cycles on each access
        idle_inputs();
        ds_start = m_ds;
        mem_valid = 1'b1; mem_dmem_req = 1'b1; mem_indirect = 1'b1;
        for (int a = 0; a < 2; a++) begin
            for (int w = 0; w < 4; w++) begin
                dmem_resp = (w == 3);
                cycle(1, "indirect");
                ind_resp[w] = mem_ind_phase;
            end
            // phase is high after the first response and clears after the second
            check("indirect.phase_after", 32'(ind_resp[3] ^ ind_resp[0]), 32'd1);
        end
        // 3 waits + held response cycle of the first access, then 3 waits of the second
        check("indirect.stall_cycles", 32'(dstall_count) - 32'(ds_start), 32'd7);

        // D-mem stall masks load-use and I-mem wait
        idle_inputs();
        mem_valid = 1'b1; mem_dmem_req = 1'b1;
        ex_dest = 3'd3; ex_is_load = 1'b1; ex_load_regfile = 1'b1;
        id_sr1_id = 3'd3; id_uses_sr1 = 1'b1; if_imem_req = 1'b1;
        ds_start = int'(lu_count);
        for (int i = 0; i < 3; i++) cycle(1, "overlap");
        check("overlap.lu_unchanged", 32'(lu_count), 32'(ds_start));
        dmem_resp = 1'b1;
        cycle(1, "overlap_resp");
        mem_valid = 1'b0; dmem_resp = 1'b0; ex_is_load = 1'b0;
        cycle(1, "overlap_after");

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            id_sr1_id = 3'($urandom_range(0, 3));
            id_sr2_id = 3'($urandom_range(0, 3));
            ex_dest = 3'($urandom_range(0, 3));
            id_uses_sr1 = 1'($urandom);
            id_uses_sr2 = 1'($urandom);
            ex_load_regfile = ($urandom_range(0, 3) != 0);
            ex_is_load = 1'($urandom);
            mem_valid = 1'($urandom);
            mem_dmem_req = 1'($urandom);
            mem_indirect = ($urandom_range(0, 3) == 0);
            dmem_resp = 1'($urandom);
            if_imem_req = 1'($urandom);
            imem_resp = 1'($urandom);
            perf_clear = ($urandom_range(0, 199) == 0);
            cycle(1, "rand");
        end

        // Saturation: drive dstall_count to 0xFFFE, then stall further and clear
        idle_inputs();
        perf_clear = 1'b1;
        cycle(1, "sat_clear");
        perf_clear = 1'b0;
        mem_valid = 1'b1; mem_dmem_req = 1'b1;
        for (int i = 0; i < 65534; i++) cycle(0, "sat_fill");
        check("sat.fffe", 32'(dstall_count), 32'h0000_FFFE);
        for (int i = 0; i < 3; i++) cycle(1, "sat");
        check("sat.ffff", 32'(dstall_count), 32'h0000_FFFF);
        perf_clear = 1'b1;
        cycle(1, "sat_clr_stall");
        perf_clear = 1'b0;
        check("sat.cleared", 32'(dstall_count), 32'd0);

        // Asynchronous reset while waiting on the second indirect access
        idle_inputs();
        mem_valid = 1'b1; mem_dmem_req = 1'b1; mem_indirect = 1'b1; dmem_resp = 1'b1;
        cycle(1, "midrst_first");
        dmem_resp = 1'b0;
        cycle(1, "midrst_ind2");
        check("midrst.in_ind2", 32'(mem_ind_phase), 32'd1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst.phase", 32'(mem_ind_phase), 32'd0);
        check("midrst.cnt", 32'({lu_count, dstall_count, istall_count} == '0), 32'd1);
        check("midrst.ctrl", 32'(dut_ctrl()), 32'(model_ctrl()));
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1, "post_reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
